// File: rtl/nscla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
package nscla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } nscla_state_t;

  // Width of the nibble index register; never narrower than one bit.
  function automatic int idx_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: generate/propagate with flattened carry terms.
// c3 is exported so the top can form signed overflow as c3 ^ c4.
module cla4_slice
  import nscla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                c4
);

  logic [NIBBLE_W-1:0] g, p;
  logic                c1, c2;

  // Lookahead carries expanded to two-level sum-of-products
  always_comb begin
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
  end

endmodule

// File: rtl/nibble_serial_cla_adder.sv
// Multi-cycle W-bit adder: one 4-bit lookahead nibble per clock, carry
// registered between nibbles, start/busy/done handshake.
// Optional macro NSCLA_OVF_EN adds a registered signed-overflow output Ovf.
module nibble_serial_cla_adder
  import nscla_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Sum,
  output logic         Cout
`ifdef NSCLA_OVF_EN
  ,
  output logic         Ovf
`endif
);

  localparam int            IW   = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  nscla_state_t state, state_nx;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_r, b_r, part_r, merged;
  logic                             carry_r;
  logic [IW-1:0]                    idx;
  logic [NIBBLE_W-1:0]              s;
  logic                             c3, c4;
  logic                             accept, last;

  assign busy   = (state == RUN);
  assign done   = (state == FIN);
  // FIN accepts a new request too, giving back-to-back operation.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (idx == LAST);

  cla4_slice u_slice (
    .x (a_r[idx]),
    .y (b_r[idx]),
    .ci(carry_r),
    .s (s),
    .c3(c3),
    .c4(c4)
  );

  // Partial sum with the current slice result dropped into nibble idx
  always_comb begin
    merged      = part_r;
    merged[idx] = s;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIN;
      FIN:     state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, nibble stepping and atomic result load on the last nibble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      part_r  <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
`ifdef NSCLA_OVF_EN
      Ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_r     <= A;
      b_r     <= B;
      carry_r <= Cin;
      idx     <= '0;
      part_r  <= '0;
    end else if (state == RUN) begin
      part_r  <= merged;
      carry_r <= c4;
      idx     <= idx + 1'b1;
      if (last) begin
        Sum  <= merged;
        Cout <= c4;
`ifdef NSCLA_OVF_EN
        Ovf  <= c3 ^ c4;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench: arithmetic reference model plus directed vectors.
module tb_nibble_serial_cla_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, Cin = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, Cout;
  logic [W-1:0] Sum;
`ifdef NSCLA_OVF_EN
  logic         Ovf;
`endif

  nibble_serial_cla_adder #(.NIBBLES(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .Cout (Cout)
`ifdef NSCLA_OVF_EN
    ,
    .Ovf  (Ovf)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Reference model: an op accepted at edge e completes after edge e+N;
  // the FIN edge (e+N+1) may accept the next op.
  int       e = 0, acc = 0, n_acc = 0, n_done = 0;
  bit       infl = 0, m_busy = 0, m_done = 0, m_ovf = 0, m_povf = 0, mon_en = 0;
  logic [W:0] pend = '0, m_res = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      infl = 0; m_busy = 0; m_done = 0; m_res = '0; m_ovf = 0;
    end else begin
      e++;
      if (infl && e == acc + N + 1) infl = 0;
      if (start && !infl) begin
        infl   = 1;
        acc    = e;
        n_acc++;
        pend   = {1'b0, A} + {1'b0, B} + (W+1)'(Cin);
        m_povf = (A[W-1] == B[W-1]) && (pend[W-1] != A[W-1]);
      end
      m_busy = infl && (e < acc + N);
      m_done = infl && (e == acc + N);
      if (m_done) begin
        m_res = pend;
        m_ovf = m_povf;
      end
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("cout_sum", 64'({Cout, Sum}), 64'(m_res));
`ifdef NSCLA_OVF_EN
      chk("ovf", 64'(Ovf), 64'(m_ovf));
`endif
      if (done) n_done++;
    end
  end

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(posedge clk); #1;
    A = a; B = b; Cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts negedges up to done.
  task automatic wait_done(input string name, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) return;
    end
    errs++; checks++;
    $display("FAIL %s: no done within 40 cycles", name);
  endtask

  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ci, input logic [W-1:0] xs, input logic xc);
    int lat, bcnt;
    drive_start(a, b, ci);
    wait_done(name, lat, bcnt);
    chk({name, " latency"}, 64'(lat - 1), 64'(N));
    chk({name, " busy_cycles"}, 64'(bcnt), 64'(N));
    chk({name, " sum"}, 64'(Sum), 64'(xs));
    chk({name, " cout"}, 64'(Cout), 64'(xc));
  endtask

  initial begin
    int lat, bcnt, dcnt, base_done;
    rst = 1'b1;
    #12;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst sum", 64'(Sum), 64'd0);
    chk("rst cout", 64'(Cout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;

    run("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
`ifdef NSCLA_OVF_EN
    run("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    chk("ovf_pos ovf", 64'(Ovf), 64'd1);
    run("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    chk("ovf_neg ovf", 64'(Ovf), 64'd1);
`endif

    // start during busy is ignored, start in FIN is accepted
    drive_start(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    A = 16'hAAAA; B = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_ign", lat, bcnt);
    chk("busy_ign sum", 64'(Sum), 64'h0100);
    chk("busy_ign cout", 64'(Cout), 64'd0);
    A = 16'hAAAA; B = 16'h5555; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b", lat, bcnt);
    chk("b2b latency", 64'(lat - 1), 64'(N));
    chk("b2b sum", 64'(Sum), 64'hFFFF);
    chk("b2b cout", 64'(Cout), 64'd0);

    // reset in the second RUN cycle discards the operation
    drive_start(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst sum", 64'(Sum), 64'd0);
    chk("midrst cout", 64'(Cout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst no_done", 64'(dcnt), 64'd0);
    run("after_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);

    // random operands, start asserted most cycles so FIN accepts are frequent
    n_acc = 0;
    base_done = n_done;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      @(negedge clk);
      A     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      B     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      Cin   = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
    end
    start = 1'b0;
    repeat (2 * N + 4) @(negedge clk);
    chk("rand accepts", 64'(n_acc >= 1000), 64'd1);
    chk("rand dones", 64'(n_done - base_done), 64'(n_acc));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
